// File: rtl/fila_pkg.sv
// Shared definitions for the fila receive FIFO.
// Holds the enqueue-handshake state encoding and the default geometry
// used to size both this FIFO and the upstream deserializer word.
package fila_pkg;

    localparam int unsigned FILA_DEPTH = 8;
    localparam int unsigned FILA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } fila_state_t;

endpackage

// File: rtl/fila_mem.sv
// Word storage for fila: synchronous write, asynchronous read, no reset.
// Ports:
//   clock_10KHz  write clock
//   we           write enable
//   waddr/wdata  write address and word
//   raddr/rdata  combinational read address and word
module fila_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock_10KHz,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries none.
    always_ff @(posedge clock_10KHz) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fila.sv
// Circular FIFO downstream of the deserializer.
// Captures one word per data_ready assertion (acknowledged with a one-cycle
// ack pulse) and lets the consumer pop one word per cycle.
// Ports:
//   clock_10KHz, reset       clock and async active-high reset
//   data_in, enqueue_in      word and valid from the deserializer
//   ack_out                  registered one-cycle acceptance pulse
//   dequeue_in               consumer pop request
//   data_out                 last popped word (registered)
//   len_out                  occupancy 0..DEPTH
//   full_out, empty_out      occupancy flags derived from len only
module fila
    import fila_pkg::*;
#(
    parameter int unsigned DEPTH = FILA_DEPTH,
    parameter int unsigned WIDTH = FILA_WIDTH
) (
    input  logic                       clock_10KHz,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       enqueue_in,
    output logic                       ack_out,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       empty_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    fila_state_t        state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   data_q, rdata;
    logic               ack_q, ack_d;
    logic               full_q, empty_q;
    logic               accept_c, pop_c;

    // FSM state register.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one word per enqueue_in assertion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept_c) state_d = ACK;
            ACK:      state_d = enqueue_in ? WAIT_LOW : IDLE;
            WAIT_LOW: if (!enqueue_in) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE, and only against start-of-cycle len.
    always_comb begin
        accept_c = 1'b0;
        ack_d    = 1'b0;
        if ((state_q == IDLE) && enqueue_in && (len_q != LEN_W'(DEPTH))) begin
            accept_c = 1'b1;
            ack_d    = 1'b1;
        end
    end

    assign pop_c = dequeue_in && (len_q != '0);

    // Pointer and occupancy next state; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({accept_c, pop_c})
            2'b10:   len_d = len_q + LEN_W'(1);
            2'b01:   len_d = len_q - LEN_W'(1);
            default: len_d = len_q;
        endcase
    end

    // Datapath registers; flags are precomputed from len_d so they are registered.
    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            ack_q    <= ack_d;
            if (pop_c) data_q <= rdata;
            full_q   <= (len_d == LEN_W'(DEPTH));
            empty_q  <= (len_d == '0);
        end
    end

    fila_mem #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_mem (
        .clock_10KHz(clock_10KHz),
        .we         (accept_c),
        .waddr      (wr_ptr_q),
        .wdata      (data_in),
        .raddr      (rd_ptr_q),
        .rdata      (rdata)
    );

    assign ack_out   = ack_q;
    assign data_out  = data_q;
    assign len_out   = len_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;

endmodule

// File: tb/tb_fila.sv
// Self-checking bench for fila: a model queue of stored words acts as the
// scoreboard; words are pushed when a handshake is driven and popped when
// the consumer dequeues, then compared against data_out.
module tb_fila;

    logic       clock_10KHz = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_q[$];
    logic [7:0] last_out;

    fila dut (
        .clock_10KHz(clock_10KHz),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .ack_out    (ack_out),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out),
        .full_out   (full_out),
        .empty_out  (empty_out)
    );

    always #5 clock_10KHz = ~clock_10KHz;

    task automatic step();
        @(posedge clock_10KHz);
        #1;
    endtask

    // Full handshake: hold enqueue_in until ack (bounded), then drop it.
    task automatic push(input logic [7:0] w);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        data_in = w;
        enqueue_in = 1'b1;
        while (!got && n < 20) begin
            step();
            n++;
            if (ack_out === 1'b1) got = 1'b1;
        end
        enqueue_in = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL push_ack word=%h: no ack within 20 cycles", w);
        end else begin
            model_q.push_back(w);
            checks++;
            if (len_out !== 4'(model_q.size())) begin
                errors++;
                $display("FAIL push_len word=%h: len_out=%0d expected %0d", w, len_out, model_q.size());
            end
        end
        step();
        checks++;
        if (ack_out !== 1'b0) begin
            errors++;
            $display("FAIL push_ack_width word=%h: ack_out=%b expected 0", w, ack_out);
        end
    endtask

    // One-cycle pop; expected word comes from the scoreboard.
    task automatic pop();
        logic [7:0] exp;
        exp = last_out;
        if (model_q.size() != 0) exp = model_q.pop_front();
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        last_out = exp;
        checks++;
        if (data_out !== exp || len_out !== 4'(model_q.size())) begin
            errors++;
            $display("FAIL pop: data_out=%h len_out=%0d expected %h len %0d",
                     data_out, len_out, exp, model_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_q.delete();
        last_out = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({len_out, empty_out, full_out, data_out, ack_out} !== {4'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: len=%0d empty=%b full=%b data=%h ack=%b expected 0/1/0/00/0",
                         i, len_out, empty_out, full_out, data_out, ack_out);
            end
        end
    endtask

    task automatic test_single_handshake();
        int acks;
        acks = 0;
        data_in = 8'hA5;
        enqueue_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ack_out === 1'b1) acks++;
        end
        enqueue_in = 1'b0;
        step();
        model_q.push_back(8'hA5);
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL single_ack_count: saw %0d ack cycles expected 1", acks);
        end
        checks++;
        if (len_out !== 4'd1 || empty_out !== 1'b0) begin
            errors++;
            $display("FAIL single_len: len_out=%0d empty=%b expected 1/0", len_out, empty_out);
        end
        pop();
        checks++;
        if (empty_out !== 1'b1) begin
            errors++;
            $display("FAIL single_empty: empty_out=%b expected 1", empty_out);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) push(8'(i));
        checks++;
        if (full_out !== 1'b1 || len_out !== 4'd8) begin
            errors++;
            $display("FAIL fill_full: full=%b len=%0d expected 1/8", full_out, len_out);
        end
        data_in = 8'h09;
        enqueue_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ack_out !== 1'b0 || len_out !== 4'd8) begin
                errors++;
                $display("FAIL overflow_refused cyc=%0d: ack=%b len=%0d expected 0/8", i, ack_out, len_out);
            end
        end
        // Pop while full: the enqueue is still refused this cycle.
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        checks++;
        if (ack_out !== 1'b0 || data_out !== 8'h01 || len_out !== 4'd7) begin
            errors++;
            $display("FAIL full_pop: ack=%b data=%h len=%0d expected 0/01/7", ack_out, data_out, len_out);
        end
        void'(model_q.pop_front());
        last_out = 8'h01;
        step();
        checks++;
        if (ack_out !== 1'b1 || len_out !== 4'd8 || full_out !== 1'b1) begin
            errors++;
            $display("FAIL late_accept: ack=%b len=%0d full=%b expected 1/8/1", ack_out, len_out, full_out);
        end
        model_q.push_back(8'h09);
        enqueue_in = 1'b0;
        step();
        for (int i = 0; i < 8; i++) pop();
        checks++;
        if (empty_out !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: empty_out=%b expected 1", empty_out);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 8; i++) pop();
        checks++;
        if (empty_out !== 1'b1 || last_out !== 8'h14) begin
            errors++;
            $display("FAIL wrap_end: empty=%b last=%h expected 1/14", empty_out, last_out);
        end
    endtask

    task automatic test_empty_and_simultaneous();
        pop();
        for (int i = 0; i < 3; i++) push(8'(8'h21 + i));
        data_in = 8'h24;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        step();
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        checks++;
        if (ack_out !== 1'b1 || data_out !== 8'h21 || len_out !== 4'd3) begin
            errors++;
            $display("FAIL simul: ack=%b data=%h len=%0d expected 1/21/3", ack_out, data_out, len_out);
        end
        void'(model_q.pop_front());
        model_q.push_back(8'h24);
        last_out = 8'h21;
        step();
        for (int i = 0; i < 3; i++) pop();
    endtask

    task automatic test_reset_mid_handshake();
        for (int i = 0; i < 3; i++) push(8'(8'h31 + i));
        data_in = 8'h55;
        enqueue_in = 1'b1;
        step();
        checks++;
        if (ack_out !== 1'b1 || len_out !== 4'd4) begin
            errors++;
            $display("FAIL mid_pre: ack=%b len=%0d expected 1/4", ack_out, len_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ack_out, len_out, empty_out, full_out, data_out} !== {1'b0, 4'd0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: ack=%b len=%0d empty=%b full=%b data=%h expected 0/0/1/0/00",
                     ack_out, len_out, empty_out, full_out, data_out);
        end
        model_q.delete();
        last_out = 8'h00;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (ack_out !== 1'b1 || len_out !== 4'd1) begin
            errors++;
            $display("FAIL fresh_accept: ack=%b len=%0d expected 1/1", ack_out, len_out);
        end
        model_q.push_back(8'h55);
        enqueue_in = 1'b0;
        step();
        pop();
    endtask

    initial begin
        reset = 1'b1;
        data_in = 8'h00;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        last_out = 8'h00;
        test_reset();
        test_single_handshake();
        test_fill_overflow();
        test_wrap();
        test_empty_and_simultaneous();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
